// File: rtl/vmem_arb_pkg.sv
// Shared types and constants for the vector/scalar memory bus arbiter.
package vmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_RESP,
    ARB_DONE
  } arb_state_e;

  localparam logic PORT_SCALAR = 1'b0;
  localparam logic PORT_VECTOR = 1'b1;

  localparam int unsigned DefaultCntW = 16;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick with lock override.
module rr_pick2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  input  logic       lock_hold_i,
  input  logic       held_idx_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  // A held lock grants only the held port; the other port waits even if it is the only one valid.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = ptr_i;
    if (lock_hold_i) begin
      grant_valid_o = valid_i[held_idx_i];
      grant_idx_o   = held_idx_i;
    end else if (valid_i[0] && valid_i[1]) begin
      grant_valid_o = 1'b1;
      grant_idx_o   = ptr_i;
    end else if (valid_i[0]) begin
      grant_valid_o = 1'b1;
      grant_idx_o   = 1'b0;
    end else if (valid_i[1]) begin
      grant_valid_o = 1'b1;
      grant_idx_o   = 1'b1;
    end
  end

endmodule

// File: rtl/vmem_bus_arbiter.sv
// Shares one 32-bit memory bus between the scalar LSU (port 0) and the VLSU (port 1),
// one outstanding access at a time, with a per-port lock for multi-word vector accesses.
module vmem_bus_arbiter
  import vmem_arb_pkg::*;
#(
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             p0_valid_i,
  input  logic             p0_write_i,
  input  logic [31:0]      p0_addr_i,
  input  logic [31:0]      p0_wdata_i,
  input  logic [3:0]       p0_wmask_i,
  input  logic             p0_lock_i,
  output logic             p0_ready_o,
  output logic             p0_resp_valid_o,
  output logic [31:0]      p0_resp_rdata_o,
  input  logic             p1_valid_i,
  input  logic             p1_write_i,
  input  logic [31:0]      p1_addr_i,
  input  logic [31:0]      p1_wdata_i,
  input  logic [3:0]       p1_wmask_i,
  input  logic             p1_lock_i,
  output logic             p1_ready_o,
  output logic             p1_resp_valid_o,
  output logic [31:0]      p1_resp_rdata_o,
  output logic             mem_valid_o,
  output logic             mem_write_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic [3:0]       mem_wmask_o,
  input  logic             mem_ready_i,
  input  logic             mem_resp_valid_i,
  input  logic [31:0]      mem_resp_rdata_i,
  output logic [CNT_W-1:0] p0_grants_o,
  output logic [CNT_W-1:0] p1_grants_o
);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic             write_q, write_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ptr_q, ptr_d;
  logic             lock_hold_q, lock_hold_d;
  logic             lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic grant_valid;
  logic grant_idx;

  rr_pick2 u_pick (
    .valid_i       ({p1_valid_i, p0_valid_i}),
    .ptr_i         (ptr_q),
    .lock_hold_i   (lock_hold_q),
    .held_idx_i    (lock_idx_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  // Next-state: capture in IDLE, track the bus handshake, retire and update lock/counters in DONE.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    rdata_d     = rdata_q;
    ptr_d       = ptr_q;
    lock_hold_d = lock_hold_q;
    lock_idx_d  = lock_idx_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          owner_d = grant_idx;
          if (grant_idx == PORT_VECTOR) begin
            write_d = p1_write_i;
            addr_d  = p1_addr_i;
            wdata_d = p1_write_i ? p1_wdata_i : 32'h0;
            wmask_d = p1_write_i ? p1_wmask_i : 4'h0;
          end else begin
            write_d = p0_write_i;
            addr_d  = p0_addr_i;
            wdata_d = p0_write_i ? p0_wdata_i : 32'h0;
            wmask_d = p0_write_i ? p0_wmask_i : 4'h0;
          end
          ptr_d   = ~grant_idx;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mem_ready_i) begin
          if (write_q) begin
            state_d = ARB_DONE;
          end else if (mem_resp_valid_i) begin
            rdata_d = mem_resp_rdata_i;
            state_d = ARB_DONE;
          end else begin
            state_d = ARB_WAIT_RESP;
          end
        end
      end
      ARB_WAIT_RESP: begin
        if (mem_resp_valid_i) begin
          rdata_d = mem_resp_rdata_i;
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        lock_idx_d = owner_q;
        if (owner_q == PORT_VECTOR) begin
          lock_hold_d = p1_lock_i;
          cnt1_d      = (cnt1_q == '1) ? cnt1_q : cnt1_q + CNT_W'(1);
        end else begin
          lock_hold_d = p0_lock_i;
          cnt0_d      = (cnt0_q == '1) ? cnt0_q : cnt0_q + CNT_W'(1);
        end
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State register; a reset drops any in-flight access without a ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      owner_q     <= PORT_SCALAR;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rdata_q     <= '0;
      ptr_q       <= PORT_SCALAR;
      lock_hold_q <= 1'b0;
      lock_idx_q  <= PORT_SCALAR;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rdata_q     <= rdata_d;
      ptr_q       <= ptr_d;
      lock_hold_q <= lock_hold_d;
      lock_idx_q  <= lock_idx_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  // Outputs decode registered state only; non-owner response lines stay at zero.
  always_comb begin
    p0_ready_o      = (state_q == ARB_DONE) && (owner_q == PORT_SCALAR);
    p1_ready_o      = (state_q == ARB_DONE) && (owner_q == PORT_VECTOR);
    p0_resp_valid_o = p0_ready_o && !write_q;
    p1_resp_valid_o = p1_ready_o && !write_q;
    p0_resp_rdata_o = p0_resp_valid_o ? rdata_q : 32'h0;
    p1_resp_rdata_o = p1_resp_valid_o ? rdata_q : 32'h0;
    mem_valid_o     = (state_q == ARB_ISSUE);
    mem_write_o     = write_q;
    mem_addr_o      = addr_q;
    mem_wdata_o     = wdata_q;
    mem_wmask_o     = wmask_q;
    p0_grants_o     = cnt0_q;
    p1_grants_o     = cnt1_q;
  end

endmodule
